adc_sequencer: RTL and testbench
================================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 RESOLUTION, 8, SAR ADC code width in bits.
REQ-002 N_CH, 4, number of analog input channels on the front-end mux (2..8).
REQ-003 SETTLE_CYCLES, 4, mux settling wait before the first conversion on a channel (>=1).
REQ-004 TIMEOUT_CYCLES, 64, maximum cycles from start pulse to ADC ready edge.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 enable_i  in  1  level; run the channel scan while high.
REQ-008 ch_mask_i  in  N_CH  per-channel scan enable.
REQ-009 osr_log2_i  in  2  oversampling: 2^osr_log2_i conversions averaged per channel.
REQ-010 clear_err_i  in  1  single-cycle pulse; clears err_o.
REQ-011 adc_start_o  out  1  start pulse to ADC.
REQ-012 adc_rdy_i  in  1  ADC ready level (goes high at conversion end, stays high until next sample phase).
REQ-013 adc_result_i  in  RESOLUTION  ADC conversion code, valid while adc_rdy_i high.
REQ-014 mux_sel_o  out  $clog2(N_CH)  analog mux channel select.
REQ-015 valid_o / ready_i  out / in  1 / 1  result handshake.
REQ-016 data_o  out  RESOLUTION  averaged code.
REQ-017 ch_o  out  $clog2(N_CH)  channel tag of data_o.
REQ-018 busy_o  out  1  high in any state other than IDLE.
REQ-019 err_o  out  1  sticky conversion-timeout flag.

Function
REQ-020 States: IDLE, SETTLE, START, WAIT, OUTPUT.
REQ-021 IDLE: when enable_i=1 and ch_mask_i!=0 -> SETTLE; select next enabled channel strictly after last served, round-robin with wrap N_CH-1 -> 0; latch channel into mux_sel_o and osr_log2_i into an internal register.
REQ-022 Otherwise IDLE holds; ch_mask_i=0 with enable_i=1 stays IDLE.
REQ-023 SETTLE: count SETTLE_CYCLES cycles, then -> START; the accumulator and sample counter clear on SETTLE entry.
REQ-024 START: adc_start_o=1 for exactly this one cycle, then -> WAIT; adc_start_o=0 in all other states.
REQ-025 WAIT: detect adc_rdy_i rising edge (registered previous value); on edge add adc_result_i, zero-extended to RESOLUTION+3 bits, into the accumulator and increment the sample count.
REQ-026 WAIT after edge: count < 2^osr -> START (no re-settle); count = 2^osr -> OUTPUT.
REQ-027 WAIT timeout: TIMEOUT_CYCLES cycles without edge -> err_o=1, burst discarded, no output, last-served pointer advances to this channel, -> IDLE.
REQ-028 OUTPUT: valid_o=1; data_o = accumulator >> latched osr (truncate); ch_o = channel; data_o/ch_o stable while valid_o=1 and ready_i=0.
REQ-029 OUTPUT handshake (valid_o & ready_i): -> IDLE in the next cycle; the next channel proceeds through IDLE (one IDLE cycle between bursts).
REQ-030 ch_mask_i, osr_log2_i, enable_i changes mid-burst do not affect the current burst; enable_i=0 mid-burst still completes and delivers the current result.
REQ-031 err_o: set on timeout, cleared by clear_err_i; set wins on the same cycle.
REQ-032 Throughput: no new start pulse while valid_o is pending (back-pressure stalls the scan).

Reset
REQ-033 Async assert: state IDLE; adc_start_o, valid_o, busy_o, err_o = 0; data_o, ch_o, mux_sel_o, accumulator, counters = 0; last-served pointer = N_CH-1 (first served channel is the lowest enabled one); rdy edge register = 0.
REQ-034 Reset mid-conversion abandons the burst; the first start pulse after release follows a full SETTLE.

Verification
REQ-035 mask=4'b1111, osr=0, ready_i=1, ADC model returns code=ch*16 -> outputs ch 0,1,2,3,0 with data 0,16,32,48,0; one start pulse per output.
REQ-036 mask=4'b0101, osr=2, model codes 10,11,12,13 on ch0 -> four start pulses, single SETTLE, data_o=11 (46>>2), ch_o=0; next output is ch2.
REQ-037 ready_i=0 for 20 cycles in OUTPUT -> valid_o, data_o held, adc_start_o stays 0; handshake -> next SETTLE after one IDLE cycle.
REQ-038 model never raises adc_rdy_i on ch1 -> err_o=1 after 64 cycles in WAIT, no valid_o for ch1, scan continues with ch2; clear_err_i -> err_o=0.
REQ-039 enable_i dropped during ch0 WAIT -> ch0 result delivered, then IDLE, busy_o=0; rst_ni pulsed in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/adc_sequencer.sv
// Round-robin SAR ADC channel sequencer: settles the mux, runs an oversampled burst of
// conversions per channel, averages them and hands the result out over a valid/ready port.
module adc_sequencer #(
  parameter int unsigned Resolution    = 8,
  parameter int unsigned NCh           = 4,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [NCh-1:0]          ch_mask_i,
  input  logic [1:0]              osr_log2_i,
  input  logic                    clear_err_i,
  output logic                    adc_start_o,
  input  logic                    adc_rdy_i,
  input  logic [Resolution-1:0]   adc_result_i,
  output logic [$clog2(NCh)-1:0]  mux_sel_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [Resolution-1:0]   data_o,
  output logic [$clog2(NCh)-1:0]  ch_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned ChW  = $clog2(NCh);
  localparam int unsigned AccW = Resolution + 3;
  localparam int unsigned TMax = (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
  localparam int unsigned TW   = $clog2(TMax + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StStart, StWait, StOutput} state_e;

  state_e                state_q;
  logic [ChW-1:0]        last_q, mux_sel_q, ch_q;
  logic [1:0]            osr_q;
  logic [AccW-1:0]       acc_q;
  logic [3:0]            cnt_q;
  logic [TW-1:0]         timer_q;
  logic                  rdy_q, start_q, valid_q, err_q;
  logic [Resolution-1:0] data_q;

  logic [ChW-1:0]        next_ch, idx;
  logic                  found;
  logic                  rdy_edge;
  logic [AccW-1:0]       acc_sum;
  logic [3:0]            cnt_inc, burst_len;

  // First enabled channel strictly after the last served one, wrapping at NCh-1.
  always_comb begin
    next_ch = last_q;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= NCh; i++) begin
      idx = ChW'((32'(last_q) + i) % NCh);
      if (!found && ch_mask_i[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rdy_edge  = adc_rdy_i & ~rdy_q;
    acc_sum   = acc_q + AccW'(adc_result_i);
    cnt_inc   = cnt_q + 4'd1;
    burst_len = 4'd1 << osr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      last_q    <= ChW'(NCh - 1);
      mux_sel_q <= '0;
      ch_q      <= '0;
      osr_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      rdy_q     <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      rdy_q <= adc_rdy_i;
      // A timeout later in this block overrides the clear.
      if (clear_err_i) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable_i && found) begin
            state_q   <= StSettle;
            mux_sel_q <= next_ch;
            osr_q     <= osr_log2_i;
            acc_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
          end
        end
        StSettle: begin
          if (timer_q == TW'(SettleCycles - 1)) begin
            timer_q <= '0;
            start_q <= 1'b1;
            state_q <= StStart;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StStart: begin
          start_q <= 1'b0;
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (rdy_edge) begin
            acc_q   <= acc_sum;
            cnt_q   <= cnt_inc;
            timer_q <= '0;
            if (cnt_inc == burst_len) begin
              valid_q <= 1'b1;
              data_q  <= Resolution'(acc_sum >> osr_q);
              ch_q    <= mux_sel_q;
              state_q <= StOutput;
            end else begin
              start_q <= 1'b1;
              state_q <= StStart;
            end
          end else if (timer_q == TW'(TimeoutCycles - 1)) begin
            // Burst is dropped; the channel still counts as served.
            err_q   <= 1'b1;
            last_q  <= mux_sel_q;
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StOutput: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= mux_sel_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_start_o = start_q;
  assign mux_sel_o   = mux_sel_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign ch_o        = ch_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a behavioural ADC that answers each start pulse
// three cycles later; optionally stays silent on channel 1.
module tb_adc_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic [3:0] ch_mask_i = 4'b0000;
  logic [1:0] osr_log2_i = 2'd0;
  logic       clear_err_i = 1'b0;
  logic       adc_start_o;
  logic       adc_rdy_i;
  logic [7:0] adc_result_i;
  logic [1:0] mux_sel_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic [1:0] ch_o;
  logic       busy_o;
  logic       err_o;

  int  total = 0;
  int  bad = 0;
  int  starts = 0;
  int  base;
  int  n;
  logic code_mode = 1'b0;
  logic block_ch1 = 1'b0;
  int  lat;
  int  conv_idx;

  adc_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .ch_mask_i    (ch_mask_i),
    .osr_log2_i   (osr_log2_i),
    .clear_err_i  (clear_err_i),
    .adc_start_o  (adc_start_o),
    .adc_rdy_i    (adc_rdy_i),
    .adc_result_i (adc_result_i),
    .mux_sel_o    (mux_sel_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .ch_o         (ch_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // ADC model: code = ch*16, or 10,11,12,... per conversion in code_mode.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adc_rdy_i    <= 1'b0;
      adc_result_i <= 8'd0;
      lat          <= 0;
      conv_idx     <= 0;
    end else if (adc_start_o) begin
      adc_rdy_i    <= 1'b0;
      lat          <= 3;
      adc_result_i <= code_mode ? 8'(10 + conv_idx) : {2'b00, mux_sel_o, 4'b0000};
      conv_idx     <= conv_idx + 1;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1 && !(block_ch1 && mux_sel_o == 2'd1)) adc_rdy_i <= 1'b1;
    end
  end

  always @(negedge clk_i) if (adc_start_o) starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!valid_o && k < 400);
    if (!valid_o) check("valid_timeout", 32'(valid_o), 32'd1);
  endtask

  task automatic wait_start(input logic [1:0] ch);
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!(adc_start_o && mux_sel_o == ch) && k < 400);
    if (!adc_start_o) check("start_timeout", 32'(adc_start_o), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (busy_o && k < 400);
    check("drain_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_start", 32'(adc_start_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_mux", 32'(mux_sel_o), 32'd0);
    rst_ni = 1'b1;

    // Full-mask round robin, one conversion per channel
    ch_mask_i = 4'b1111;
    enable_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      base = starts;
      wait_valid();
      check("rr_ch", 32'(ch_o), 32'(i % 4));
      check("rr_data", 32'(data_o), 32'((i % 4) * 16));
      check("rr_starts", 32'(starts - base), 32'd1);
    end
    enable_i = 1'b0;
    drain();

    // Oversampling x4 on ch0, then ch2 next
    do_reset();
    code_mode  = 1'b1;
    osr_log2_i = 2'd2;
    ch_mask_i  = 4'b0101;
    enable_i   = 1'b1;
    base = starts;
    wait_valid();
    check("osr_ch", 32'(ch_o), 32'd0);
    check("osr_data", 32'(data_o), 32'd11);
    check("osr_starts", 32'(starts - base), 32'd4);
    wait_valid();
    check("osr_next_ch", 32'(ch_o), 32'd2);
    check("osr_next_data", 32'(data_o), 32'd15);
    enable_i = 1'b0;
    drain();

    // Back-pressure holds the result and stalls the scan
    do_reset();
    code_mode  = 1'b0;
    osr_log2_i = 2'd0;
    ch_mask_i  = 4'b1111;
    ready_i    = 1'b0;
    enable_i   = 1'b1;
    wait_valid();
    check("bp_ch", 32'(ch_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("bp_valid", 32'(valid_o), 32'd1);
      check("bp_data", 32'(data_o), 32'd0);
      check("bp_nostart", 32'(adc_start_o), 32'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_idle_busy", 32'(busy_o), 32'd0);
    check("bp_idle_valid", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    check("bp_settle_busy", 32'(busy_o), 32'd1);
    check("bp_settle_mux", 32'(mux_sel_o), 32'd1);
    enable_i = 1'b0;
    drain();

    // Timeout on ch1
    do_reset();
    block_ch1 = 1'b1;
    enable_i  = 1'b1;
    wait_valid();
    check("to_ch0", 32'(ch_o), 32'd0);
    wait_start(2'd1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!err_o && n < 200);
    check("to_latency", 32'(n), 32'd65);
    wait_valid();
    check("to_next_ch", 32'(ch_o), 32'd2);
    check("to_next_data", 32'(data_o), 32'd32);
    check("to_err_sticky", 32'(err_o), 32'd1);
    enable_i = 1'b0;
    drain();
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    check("to_err_clear", 32'(err_o), 32'd0);
    block_ch1 = 1'b0;

    // Enable drop mid-burst, then reset in WAIT
    do_reset();
    ch_mask_i = 4'b0001;
    enable_i  = 1'b1;
    wait_start(2'd0);
    @(negedge clk_i);
    enable_i = 1'b0;
    wait_valid();
    check("en_ch", 32'(ch_o), 32'd0);
    @(negedge clk_i);
    check("en_idle", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk_i);
    check("en_stays_idle", 32'(busy_o), 32'd0);
    ch_mask_i = 4'b0100;
    enable_i  = 1'b1;
    wait_valid();
    check("rw_ch", 32'(ch_o), 32'd2);
    check("rw_data", 32'(data_o), 32'd32);
    wait_start(2'd2);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rw_busy", 32'(busy_o), 32'd0);
    check("rw_start", 32'(adc_start_o), 32'd0);
    check("rw_valid", 32'(valid_o), 32'd0);
    check("rw_data0", 32'(data_o), 32'd0);
    check("rw_ch0", 32'(ch_o), 32'd0);
    check("rw_mux0", 32'(mux_sel_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!adc_start_o && n < 50);
    check("rw_settle_len", 32'(n), 32'd5);
    check("rw_restart_mux", 32'(mux_sel_o), 32'd2);
    enable_i = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
